// File: rtl/bus_pkg.sv
// Shared definitions for the two-master bus arbiter.
//   - arb_state_t : FSM state encoding (IDLE / GNT0 / GNT1)
//   - ADDR_W, DATA_W : bus address and data widths
//   - SLV_HI, SLV_LO : position of the slave-select field inside the address
//   - CNT_W : width of the hold counter (covers HOLD_LIMIT up to 255)
//   - slave_field() : extracts the slave-select field from an address
package bus_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int SLV_HI = 7;
  localparam int SLV_LO = 5;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } arb_state_t;

  function automatic logic [SLV_HI-SLV_LO:0] slave_field(input logic [ADDR_W-1:0] addr);
    return addr[SLV_HI:SLV_LO];
  endfunction

endpackage

// File: rtl/arb_hold_cnt.sv
// Hold counter for the bus arbiter: counts the cycles the current owner has
// held the bus and flags the last cycle before the hold limit expires.
// Ports:
//   clk      : clock
//   reset    : synchronous active-high reset, counter -> 0
//   clear    : load 0 on this edge (entry into a grant state)
//   enable   : count this cycle (a grant state is active)
//   limit    : hold limit; the count saturates at this value
//   at_limit : count == limit-1, i.e. this is the final allowed grant cycle
module arb_hold_cnt
  import bus_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             at_limit
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != limit)) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign at_limit = (count_reg == (limit - CNT_W'(1)));

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with registered one-hot grants, a bounded hold time
// while the other master waits, and a combinational bus mux toward the
// address decoder / slaves.
// Configuration macro: BUS_ARB_ROUND_ROBIN_EN
//   defined   : ties in IDLE go to the master that was not granted last,
//               and either master can be preempted after HOLD_LIMIT cycles.
//   undefined : M0 wins ties and is never preempted; only M1 is preempted.
// Parameters:
//   HOLD_LIMIT : max consecutive grant cycles while the other master requests (2..255)
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   M0_req/M1_req              : master requests, held for the whole transaction
//   M0_wr/M1_wr                : master write enables
//   M0_address/M1_address      : master addresses ([7:5] selects the slave)
//   M0_wdata/M1_wdata          : master write data
//   M0_grant/M1_grant          : registered grants, one-hot or zero
//   S_req, S_wr, S_address, S_wdata : bus toward decoder and slaves
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int HOLD_LIMIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              M0_req,
  input  logic              M1_req,
  input  logic              M0_wr,
  input  logic              M1_wr,
  input  logic [ADDR_W-1:0] M0_address,
  input  logic [ADDR_W-1:0] M1_address,
  input  logic [DATA_W-1:0] M0_wdata,
  input  logic [DATA_W-1:0] M1_wdata,
  output logic              M0_grant,
  output logic              M1_grant,
  output logic              S_req,
  output logic              S_wr,
  output logic [ADDR_W-1:0] S_address,
  output logic [DATA_W-1:0] S_wdata
);

`ifdef BUS_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  arb_state_t state_reg, state_next;
  // 0 = M0 granted most recently, 1 = M1
  logic       last_grant_reg, last_grant_next;
  logic       at_limit;
  logic       grant_entry;

  // In fixed-priority mode last_grant is still tracked but never steers a tie.
  logic       tie_to_m1;
  assign tie_to_m1 = RR_EN && !last_grant_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (M0_req && M1_req) state_next = tie_to_m1 ? GNT1 : GNT0;
        else if (M0_req)      state_next = GNT0;
        else if (M1_req)      state_next = GNT1;
      end
      GNT0: begin
        if (!M0_req)                          state_next = M1_req ? GNT1 : IDLE;
        else if (RR_EN && M1_req && at_limit) state_next = GNT1;
      end
      GNT1: begin
        if (!M1_req)                 state_next = M0_req ? GNT0 : IDLE;
        else if (M0_req && at_limit) state_next = GNT0;
      end
      default: state_next = IDLE;
    endcase
  end

  // Any change into a grant state (from IDLE or a direct handoff) restarts the hold count.
  assign grant_entry = (state_next != state_reg) && (state_next != IDLE);

  always_comb begin
    last_grant_next = last_grant_reg;
    if (grant_entry) last_grant_next = (state_next == GNT1);
  end

  arb_hold_cnt u_hold_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (grant_entry),
    .enable   (state_reg != IDLE),
    .limit    (CNT_W'(HOLD_LIMIT)),
    .at_limit (at_limit)
  );

  assign M0_grant = (state_reg == GNT0);
  assign M1_grant = (state_reg == GNT1);

  // Bus fields are gated by the owner's req so a dropping master cannot leak stale values.
  always_comb begin
    S_req     = 1'b0;
    S_wr      = 1'b0;
    S_address = '0;
    S_wdata   = '0;
    case (state_reg)
      GNT0: begin
        S_req     = M0_req;
        S_wr      = M0_wr & M0_req;
        S_address = M0_address & {ADDR_W{M0_req}};
        S_wdata   = M0_wdata & {DATA_W{M0_req}};
      end
      GNT1: begin
        S_req     = M1_req;
        S_wr      = M1_wr & M1_req;
        S_address = M1_address & {ADDR_W{M1_req}};
        S_wdata   = M1_wdata & {DATA_W{M1_req}};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter (HOLD_LIMIT=16). Stimulus pushes the
// expected post-edge outputs into a queue; a monitor pops and compares one
// entry per clock, 1 time unit after the rising edge.
module tb_bus_arbiter;

`ifdef BUS_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        M0_req, M1_req, M0_wr, M1_wr;
  logic [7:0]  M0_address, M1_address;
  logic [31:0] M0_wdata, M1_wdata;
  logic        M0_grant, M1_grant, S_req, S_wr;
  logic [7:0]  S_address;
  logic [31:0] S_wdata;

  always #5 clk = ~clk;

  bus_arbiter #(.HOLD_LIMIT(16)) dut (
    .clk(clk), .reset(reset),
    .M0_req(M0_req), .M1_req(M1_req), .M0_wr(M0_wr), .M1_wr(M1_wr),
    .M0_address(M0_address), .M1_address(M1_address),
    .M0_wdata(M0_wdata), .M1_wdata(M1_wdata),
    .M0_grant(M0_grant), .M1_grant(M1_grant),
    .S_req(S_req), .S_wr(S_wr), .S_address(S_address), .S_wdata(S_wdata)
  );

  typedef struct packed {
    logic        g0;
    logic        g1;
    logic        sreq;
    logic        swr;
    logic [7:0]  saddr;
    logic [31:0] swdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn = 0;

  // Push the outputs expected after the next edge, given the hand-derived grant.
  task automatic tick(input logic g0, input logic g1);
    exp_t e;
    e = '0;
    e.g0 = g0;
    e.g1 = g1;
    if (g0) begin
      e.sreq = M0_req; e.swr = M0_wr & M0_req;
      e.saddr = M0_address & {8{M0_req}}; e.swdata = M0_wdata & {32{M0_req}};
    end else if (g1) begin
      e.sreq = M1_req; e.swr = M1_wr & M1_req;
      e.saddr = M1_address & {8{M1_req}}; e.swdata = M1_wdata & {32{M1_req}};
    end
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        txn++;
        checks++;
        if ({M0_grant, M1_grant} !== {e.g0, e.g1}) begin
          errors++;
          $display("FAIL grant txn %0d got %b%b exp %b%b", txn, M0_grant, M1_grant, e.g0, e.g1);
        end
        checks++;
        if ({S_req, S_wr, S_address, S_wdata} !== {e.sreq, e.swr, e.saddr, e.swdata}) begin
          errors++;
          $display("FAIL bus txn %0d got req=%b wr=%b addr=%h wdata=%h exp req=%b wr=%b addr=%h wdata=%h",
                   txn, S_req, S_wr, S_address, S_wdata, e.sreq, e.swr, e.saddr, e.swdata);
        end
        $display("txn %0d grant=%b%b bus req=%b wr=%b addr=%h wdata=%h",
                 txn, M0_grant, M1_grant, S_req, S_wr, S_address, S_wdata);
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog timeout got running exp finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic g0;
    reset = 1'b1;
    M0_req = 1'b1; M1_req = 1'b1;
    M0_wr = 1'b0; M0_address = 8'h4A; M0_wdata = 32'h1111_2222;
    M1_wr = 1'b1; M1_address = 8'hC3; M1_wdata = 32'h3333_4444;

    // Reset with both requesting: no grant while reset is held.
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    reset = 1'b0;

    // First tie goes to M0; then M0 holds for 40 cycles with M1 waiting.
    for (int n = 0; n < 40; n++) begin
      g0 = RR ? (((n / 16) % 2) == 0) : 1'b1;
      tick(g0, !g0);
    end

    // M0 drops: handoff to M1 on the very next edge.
    M0_req = 1'b0;
    tick(1'b0, 1'b1);
    M1_req = 1'b0;
    tick(1'b0, 1'b0);

    // M1 alone, write to 8'h25; M0 inputs busy but not requesting.
    M0_wr = 1'b1; M0_address = 8'h9F; M0_wdata = 32'hCAFE_F00D;
    M1_req = 1'b1; M1_wr = 1'b1; M1_address = 8'h25; M1_wdata = 32'hDEAD_BEEF;
    tick(1'b0, 1'b1);
    M1_req = 1'b0;
    tick(1'b0, 1'b0);

    // Two consecutive ties from IDLE (last grant was M1).
    M0_req = 1'b1; M1_req = 1'b1;
    tick(1'b1, 1'b0);
    M0_req = 1'b0; M1_req = 1'b0;
    tick(1'b0, 1'b0);
    M0_req = 1'b1; M1_req = 1'b1;
    tick(!RR, RR);
    M0_req = 1'b0; M1_req = 1'b0;
    tick(1'b0, 1'b0);

    // Reset pulse in the middle of a GNT1 tenure.
    M1_req = 1'b1; M1_wr = 1'b0; M1_address = 8'h61; M1_wdata = 32'h0BAD_CAFE;
    for (int n = 0; n < 5; n++) tick(1'b0, 1'b1);
    reset = 1'b1;
    tick(1'b0, 1'b0);
    reset = 1'b0;
    tick(1'b0, 1'b1);
    // M0 starts waiting; M1 must be preempted after exactly 16 grant cycles.
    M0_req = 1'b1;
    for (int n = 1; n < 16; n++) tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    M0_req = 1'b0; M1_req = 1'b0;
    tick(1'b0, 1'b0);

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
